// File: rtl/median_5x5_bitserial_filter.sv
// median_5x5_bitserial_filter: gathers five 5-pixel columns into a 5x5 window and finds its median
// by MSB-first bit-serial radix select, one result bit per cycle.
module median_5x5_bitserial_filter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable_5x5,
    input  logic [5*DATA_WIDTH-1:0]   i_col,
    output logic [DATA_WIDTH-1:0]     o_median,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic                      o_overrun,
    output logic [2:0]                o_col_cnt,
    output logic [1:0]                o_state
);
    localparam int BW = DATA_WIDTH > 2 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SELECT = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]              state, state_nxt;
    logic [5*DATA_WIDTH-1:0] cols [4];
    logic [DATA_WIDTH-1:0]   ops [25];
    logic [24:0]             active, bit_b;
    logic [4:0]              k, zeros;
    logic [BW-1:0]           b;
    logic [DATA_WIDTH-1:0]   result, result_nxt;
    logic                    win_done, accept, take_zero;

    assign win_done = i_enable_5x5 && o_col_cnt == 3'd4;
    assign accept   = win_done && state != SELECT;

    // zeros counts surviving candidates whose current bit is 0
    always_comb begin
        zeros = '0;
        bit_b = '0;
        for (int i = 0; i < 25; i++) begin
            bit_b[i] = ops[i][b];
            zeros = zeros + 5'(active[i] & ~ops[i][b]);
        end
        take_zero = zeros >= k;
        result_nxt = result;
        result_nxt[b] = ~take_zero;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == SELECT ? (b == '0 ? DONE : SELECT) : (accept ? SELECT : IDLE);
    end

    always_comb begin
        o_busy  = state == SELECT;
        o_valid = state == DONE;
        o_state = state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_col_cnt <= '0;
            o_overrun <= 1'b0;
            for (int c = 0; c < 4; c++) cols[c] <= '0;
        end else begin
            o_overrun <= win_done && state == SELECT;
            if (i_enable_5x5) begin
                if (o_col_cnt != 3'd4) cols[o_col_cnt[1:0]] <= i_col;
                o_col_cnt <= o_col_cnt == 3'd4 ? 3'd0 : o_col_cnt + 3'd1;
            end
        end
    end

    // the fifth column bypasses the column store straight into the operands
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 25; i++) ops[i] <= '0;
            active   <= '0;
            k        <= '0;
            b        <= '0;
            result   <= '0;
            o_median <= '0;
        end else if (accept) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 5; r++)
                    ops[c*5+r] <= cols[c][DATA_WIDTH*r +: DATA_WIDTH];
            for (int r = 0; r < 5; r++) ops[20+r] <= i_col[DATA_WIDTH*r +: DATA_WIDTH];
            active <= '1;
            k      <= 5'd13;
            b      <= BW'(DATA_WIDTH - 1);
            result <= '0;
        end else if (state == SELECT) begin
            active <= active & (take_zero ? ~bit_b : bit_b);
            k      <= take_zero ? k : k - zeros;
            result <= result_nxt;
            b      <= b - BW'(1);
            if (b == '0) o_median <= result_nxt;
        end
    end
endmodule

// File: tb/tb_median_5x5_bitserial_filter.sv
// tb_median_5x5_bitserial_filter: table vectors, random windows against a sorting model,
// and hand-written cadence, overrun and mid-select reset sequences.
module tb_median_5x5_bitserial_filter;
    localparam int DW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_enable_5x5;
    logic [5*DW-1:0] i_col;
    logic [DW-1:0] o_median;
    logic          o_valid, o_busy, o_overrun;
    logic [2:0]    o_col_cnt;
    logic [1:0]    o_state;

    median_5x5_bitserial_filter #(.DATA_WIDTH(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable_5x5(i_enable_5x5), .i_col(i_col),
        .o_median(o_median), .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun),
        .o_col_cnt(o_col_cnt), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [25*DW-1:0] pix;
        logic [DW-1:0]    req;
    } vec_t;

    vec_t tbl [5];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] med(input logic [25*DW-1:0] p);
        logic [DW-1:0] q[$];
        for (int i = 0; i < 25; i++) q.push_back(p[i*DW +: DW]);
        q.sort();
        return q[12];
    endfunction

    function automatic logic [5*DW-1:0] col_of(input logic [25*DW-1:0] p, input int c);
        logic [5*DW-1:0] col;
        for (int r = 0; r < 5; r++) col[r*DW +: DW] = p[(r*5+c)*DW +: DW];
        return col;
    endfunction

    function automatic logic [25*DW-1:0] rand_win();
        logic [25*DW-1:0] p;
        bit dup;
        dup = $urandom_range(0, 1) == 1;
        for (int i = 0; i < 25; i++) p[i*DW +: DW] = dup ? DW'($urandom_range(0, 3) * 85) : DW'($urandom);
        return p;
    endfunction

    task automatic run_window(input logic [25*DW-1:0] pix, input logic [DW-1:0] req, input bit gaps, input string nm);
        int n;
        for (int c = 0; c < 5; c++) begin
            i_enable_5x5 = 1'b1;
            i_col = col_of(pix, c);
            @(posedge i_clk); #1;
            i_enable_5x5 = 1'b0;
            check({nm, "_colcnt"}, int'(o_col_cnt), (c + 1) % 5);
            if (gaps && c < 4) begin
                n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++) begin @(posedge i_clk); #1; end
                check({nm, "_colhold"}, int'(o_col_cnt), c + 1);
            end
        end
        n = 0;
        while (!o_valid && n < 20) begin @(posedge i_clk); #1; n++; end
        check({nm, "_latency"}, n, 8);
        check({nm, "_median"}, int'(o_median), int'(req));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int a[25];
        int j, t, nv, no;
        logic [25*DW-1:0] wp[5];
        logic [DW-1:0] we[5];
        for (int i = 0; i < 25; i++) begin
            tbl[0].pix[i*DW +: DW] = DW'(100);
            tbl[1].pix[i*DW +: DW] = DW'(i);
            tbl[3].pix[i*DW +: DW] = (i % 2 == 0) ? DW'(255) : DW'(0);
            tbl[4].pix[i*DW +: DW] = (i % 2 == 0) ? DW'(0) : DW'(255);
            a[i] = i;
        end
        for (int i = 24; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = a[i]; a[i] = a[j]; a[j] = t;
        end
        for (int i = 0; i < 25; i++) tbl[2].pix[i*DW +: DW] = DW'(a[i]);
        tbl[0].req = 100; tbl[1].req = 12; tbl[2].req = 12; tbl[3].req = 255; tbl[4].req = 0;

        i_rst = 1'b1; i_enable_5x5 = 1'b0; i_col = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_median", int'(o_median), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_overrun", int'(o_overrun), 0);
        check("rst_colcnt", int'(o_col_cnt), 0);
        check("rst_state", int'(o_state), 0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        for (int v = 0; v < 5; v++) begin
            run_window(tbl[v].pix, tbl[v].req, 1'b0, $sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_model", v), int'(med(tbl[v].pix)), int'(tbl[v].req));
        end

        for (int v = 0; v < 20; v++) begin
            wp[0] = rand_win();
            run_window(wp[0], med(wp[0]), 1'b1, "rnd");
        end
        repeat (2) @(posedge i_clk);
        #1;

        // controller cadence: 5 enables on, 4 off, five windows back to back
        for (int w = 0; w < 5; w++) begin wp[w] = rand_win(); we[w] = med(wp[w]); end
        nv = 0; no = 0;
        for (int i = 0; i < 60; i++) begin
            if (i < 45 && i % 9 < 5) begin i_enable_5x5 = 1'b1; i_col = col_of(wp[i / 9], i % 9); end
            else i_enable_5x5 = 1'b0;
            @(posedge i_clk); #1;
            if (o_overrun) no++;
            if (i == 13) check("cad_accept_busy", int'(o_busy), 1);
            if (o_valid) begin
                if (nv < 5) begin
                    check("cad_time", i, 9 * nv + 12);
                    check("cad_median", int'(o_median), int'(we[nv]));
                end
                nv++;
            end
        end
        i_enable_5x5 = 1'b0;
        check("cad_valid_count", nv, 5);
        check("cad_overrun_count", no, 0);

        // ten consecutive enables: second window lands during SELECT
        wp[0] = rand_win(); wp[1] = rand_win();
        nv = 0; no = 0;
        for (int i = 0; i < 25; i++) begin
            if (i < 10) begin i_enable_5x5 = 1'b1; i_col = col_of(wp[i / 5], i % 5); end
            else i_enable_5x5 = 1'b0;
            @(posedge i_clk); #1;
            if (o_overrun) begin no++; check("ovr_time", i, 9); end
            if (i == 9) check("ovr_colcnt", int'(o_col_cnt), 0);
            if (o_valid) begin
                nv++;
                check("ovr_valid_time", i, 12);
                check("ovr_median", int'(o_median), int'(med(wp[0])));
            end
        end
        check("ovr_valid_count", nv, 1);
        check("ovr_overrun_count", no, 1);

        // reset while the engine is at bit 4
        for (int i = 0; i < 25; i++) wp[0][i*DW +: DW] = DW'(77);
        run_window(wp[0], 77, 1'b0, "pre_rst");
        for (int i = 0; i < 25; i++) wp[1][i*DW +: DW] = DW'(50);
        for (int c = 0; c < 5; c++) begin
            i_enable_5x5 = 1'b1; i_col = col_of(wp[1], c);
            @(posedge i_clk); #1;
        end
        i_enable_5x5 = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("mid_busy", int'(o_busy), 1);
        i_rst = 1'b1;
        #1;
        check("mid_rst_median", int'(o_median), 0);
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_colcnt", int'(o_col_cnt), 0);
        check("mid_rst_state", int'(o_state), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge i_clk); #1;
            if (o_valid) nv++;
        end
        check("mid_rst_no_valid", nv, 0);
        run_window(tbl[2].pix, 12, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/median_5x5_bitserial_filter.md
Name: median_5x5_bitserial_filter

Overview:
- Downstream consumer of the 5x5 median enable controller.
- Each cycle the controller's enable is high, the block captures one 5-pixel column read from BRAM.
- After 5 captured columns it snapshots the 25-pixel window and computes the median (13th smallest) with an MSB-first bit-serial radix-select engine, one bit per cycle.
- Result goes to the MRELBP feature stage as a registered pixel with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 8, pixel width in bits (legal range 2..16)

Ports:
i_clk  input  1  global clock, rising edge
i_rst  input  1  global reset, asynchronous, active-high
i_enable_5x5  input  1  column strobe from the controller; i_col is sampled when high
i_col  input  5*DATA_WIDTH  one window column; row r at bits [DATA_WIDTH*r +: DATA_WIDTH], r=0..4
o_median  output  DATA_WIDTH  median of the last computed window; held between results
o_valid  output  1  one-cycle pulse, o_median is new
o_busy  output  1  engine in SELECT state
o_overrun  output  1  one-cycle pulse, completed window dropped because the engine was busy
o_col_cnt  output  3  columns captured in the current window, 0..4
o_state  output  2  engine state, for test: IDLE=0, SELECT=1, DONE=2

Behaviour:
- Reset values: o_median=0, o_valid=0, o_busy=0, o_overrun=0, o_col_cnt=0, o_state=IDLE. Column registers, active mask, k, bit index and result are all cleared.
- Reset mid-operation: the partial window is discarded, the engine aborts, and no o_valid is produced for the aborted window.
- Column capture:
  - On a clock edge with i_enable_5x5=1, i_col is stored at column slot o_col_cnt.
  - If o_col_cnt<4, o_col_cnt increments.
  - If o_col_cnt==4, the window is complete and o_col_cnt wraps to 0.
  - With enable low, o_col_cnt and the column registers hold. Gaps inside a window are allowed.
- Window launch: a complete window is accepted only when the engine is in IDLE or DONE.
  - On acceptance, all 25 pixels (4 stored columns plus the incoming i_col) are copied into the engine operand registers in the same edge.
  - If the engine is in SELECT, the window is dropped, o_overrun pulses for one cycle, and the current computation continues untouched.
- Engine FSM:
  - IDLE -> SELECT on acceptance. Load: active mask = all 25 ones, k=13 (5 bits), bit index b=DATA_WIDTH-1.
  - SELECT, each cycle:
    - zeros = popcount(active & ~bit_b of each operand), range 0..25.
    - If zeros>=k: result[b]=0, active &= operands with bit_b==0.
    - Else: result[b]=1, k=k-zeros, active &= operands with bit_b==1.
    - Decrement b. After processing b==0, go to DONE and register the result into o_median.
  - DONE lasts exactly one cycle with o_valid=1, then goes to IDLE, or back to SELECT if a window is accepted in that same cycle.
- Latency: if the 5th column is sampled in cycle c, o_valid=1 in cycle c+DATA_WIDTH+1 (c+9 for 8 bits).
  - Throughput is one window per DATA_WIDTH+1 cycles.
  - This matches the controller cadence: 5 enable cycles + 4 new-row cycles.
- Arithmetic invariants:
  - k stays in 1..25, so k never underflows.
  - popcount is unsigned 5-bit.
  - Duplicates are handled naturally: the active set always contains the k-th smallest.
- Simultaneous events:
  - Window completion in DONE: o_valid for the old result and acceptance of the new window happen in the same cycle.
  - Window completion in SELECT: o_overrun=1, and o_col_cnt still wraps to 0.
- o_busy = (o_state==SELECT). o_median changes only on entry to DONE.

Test Plan:
- Reset, then 5 enables with every pixel=100 -> o_valid exactly 9 cycles after the 5th enable, o_median=100, o_col_cnt back to 0.
- Window with pixels 0..24 in row-major order, then the same values shuffled -> o_median=12 both times.
- 13 pixels=255 and 12 pixels=0 -> 255; then 13 pixels=0 and 12 pixels=255 -> 0. Duplicate and extreme boundaries.
- Controller cadence (5 enables on, 4 off), 5 windows back-to-back -> 5 o_valid pulses at 9-cycle spacing, o_overrun never asserted, the 2nd window accepted in the same cycle as the 1st o_valid.
- 10 consecutive enables -> 1st window computed; 2nd completes during SELECT -> o_overrun pulse at the 10th enable, no second o_valid, o_col_cnt=0.
- Assert i_rst for 1 cycle mid-SELECT (b=4) -> outputs return to reset values immediately, no o_valid follows; the next full window produces a correct median.
